// File: rtl/frogger_pkg.sv
// Shared types and widths for the lane scheduling logic of the frogger game.
package frogger_pkg;

  localparam int LEVEL_W       = 3;
  localparam int NUM_LANES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CRASH = 2'd3
  } sched_state_t;

endpackage

// File: rtl/traffic_scheduler_lane_timer.sv
// One lane's period counter: counts down while running, flags expiry at zero and
// reloads with the level-dependent period that is in effect in the expiry cycle.
module lane_timer
  import frogger_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int LANE       = 0,
  parameter int BASE       = 16,
  parameter int STRIDE     = 4,
  parameter int LEVEL_STEP = 2,
  parameter int MIN_PERIOD = 4
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               run,
  input  logic               hold_reload,
  input  logic [LEVEL_W-1:0] level,
  output logic               expire
);

  localparam int LANE_BASE  = BASE + LANE * STRIDE;
  localparam int RST_PERIOD = (LANE_BASE < MIN_PERIOD) ? MIN_PERIOD : LANE_BASE;

  localparam logic signed [CNT_W:0] BASE_S = (CNT_W+1)'(LANE_BASE);
  localparam logic signed [CNT_W:0] STEP_S = (CNT_W+1)'(LEVEL_STEP);
  localparam logic signed [CNT_W:0] MIN_S  = (CNT_W+1)'(MIN_PERIOD);

  logic signed [CNT_W:0] raw;
  logic [CNT_W-1:0]      reload;
  logic [CNT_W-1:0]      cnt;

  // One extra signed bit keeps high levels from wrapping below the floor.
  always_comb begin
    raw    = BASE_S - STEP_S * $signed((CNT_W+1)'(level));
    reload = (raw < MIN_S) ? MIN_S[CNT_W-1:0] - CNT_W'(1) : raw[CNT_W-1:0] - CNT_W'(1);
  end

  assign expire = run && (cnt == '0);

  always_ff @(posedge clk) begin
    if (RST) begin
      cnt <= CNT_W'(RST_PERIOD - 1);
    end else if (hold_reload) begin
      cnt <= reload;
    end else if (run) begin
      cnt <= (cnt == '0) ? reload : cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_scheduler.sv
// Run/pause/crash sequencing and one-step-per-cycle lane grant for the car lanes.
// lane_step is a registered one-hot/zero pulse; lane 0 has the highest priority.
module traffic_scheduler
  import frogger_pkg::*;
#(
  parameter int NUM_LANES     = NUM_LANES_DEF,
  parameter int CNT_W         = 24,
  parameter int PERIOD_BASE   = 16,
  parameter int PERIOD_STRIDE = 4,
  parameter int LEVEL_STEP    = 2,
  parameter int MIN_PERIOD    = 4,
  parameter int MAX_LEVEL     = 7,
  parameter int CRASH_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 level_up,
  input  logic                 hit,
  output logic [NUM_LANES-1:0] lane_step,
  output logic [LEVEL_W-1:0]   level,
  output logic [1:0]           state,
  output logic                 overrun
);

  localparam int CRASH_W = $clog2(CRASH_CYCLES) + 1;

  sched_state_t         state_q, state_d;
  logic [CRASH_W-1:0]   crash_cnt;
  logic [NUM_LANES-1:0] expire, pending, req, grant;
  logic                 run, hold;

  assign run   = (state_q == RUN);
  assign hold  = (state_q == IDLE) || (state_q == CRASH);
  assign state = state_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_timer #(
      .CNT_W     (CNT_W),
      .LANE      (i),
      .BASE      (PERIOD_BASE),
      .STRIDE    (PERIOD_STRIDE),
      .LEVEL_STEP(LEVEL_STEP),
      .MIN_PERIOD(MIN_PERIOD)
    ) u_timer (
      .clk        (clk),
      .RST        (RST),
      .run        (run),
      .hold_reload(hold),
      .level      (level),
      .expire     (expire[i])
    );
  end

  // Lowest set bit of req wins; everything else waits in pending.
  assign req   = pending | (run ? expire : '0);
  assign grant = req & (~req + NUM_LANES'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (hit)        state_d = CRASH;
        else if (pause) state_d = PAUSE;
      end
      PAUSE:   if (!pause) state_d = RUN;
      CRASH:   if (crash_cnt == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      crash_cnt <= '0;
      pending   <= '0;
      lane_step <= '0;
      level     <= '0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_step <= run ? grant : '0;

      if (run && state_d == CRASH)
        crash_cnt <= CRASH_W'(CRASH_CYCLES - 1);
      else if (state_q == CRASH && crash_cnt != '0)
        crash_cnt <= crash_cnt - CRASH_W'(1);

      // Pending is frozen in PAUSE so a resumed game keeps its queued steps.
      if (run)
        pending <= req & ~grant;
      else if (hold)
        pending <= '0;

      if (run && |(expire & pending))
        overrun <= 1'b1;

      if (run && level_up && !hit && level != LEVEL_W'(MAX_LEVEL))
        level <= level + LEVEL_W'(1);
    end
  end

endmodule

// File: tb/tb_traffic_scheduler.sv
// Bench for traffic_scheduler: a default-parameter instance and a short-period
// instance that provokes overrun, both tracked by a cycle-by-cycle reference model.
module tb_traffic_scheduler;
  import frogger_pkg::*;

  localparam int NL = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_start, a_pause, a_lvl, a_hit;
  logic b_rst, b_start, b_pause, b_lvl, b_hit;
  logic [NL-1:0] a_step, b_step;
  logic [2:0]    a_level, b_level;
  logic [1:0]    a_state, b_state;
  logic          a_ovr, b_ovr;

  traffic_scheduler u_a (
    .clk(clk), .RST(a_rst), .start(a_start), .pause(a_pause), .level_up(a_lvl), .hit(a_hit),
    .lane_step(a_step), .level(a_level), .state(a_state), .overrun(a_ovr)
  );

  traffic_scheduler #(
    .PERIOD_BASE(2), .PERIOD_STRIDE(0), .LEVEL_STEP(1), .MIN_PERIOD(1)
  ) u_b (
    .clk(clk), .RST(b_rst), .start(b_start), .pause(b_pause), .level_up(b_lvl), .hit(b_hit),
    .lane_step(b_step), .level(b_level), .state(b_state), .overrun(b_ovr)
  );

  // ---------------- reference model ----------------
  int P_BASE[2] = '{16, 2};
  int P_STR[2]  = '{4, 0};
  int P_LS[2]   = '{2, 1};
  int P_MIN[2]  = '{4, 1};

  int m_st[2], m_lv[2], m_cc[2], m_step[2];
  int m_cnt[2][NL];
  bit m_pend[2][NL];
  bit m_ovr[2];

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int per(input int k, input int i, input int lv);
    int p;
    p = P_BASE[k] + i * P_STR[k] - lv * P_LS[k];
    return (p < P_MIN[k]) ? P_MIN[k] : p;
  endfunction

  // Advance the model by one clock using the inputs applied in that cycle.
  task automatic model_step(input int k, input bit rst, input bit st, input bit pz,
                            input bit lu, input bit ht);
    bit ex[NL];
    int g;
    g = -1;
    if (rst) begin
      m_st[k] = 0; m_lv[k] = 0; m_ovr[k] = 1'b0; m_step[k] = 0; m_cc[k] = 0;
      for (int i = 0; i < NL; i++) begin
        m_cnt[k][i] = per(k, i, 0) - 1;
        m_pend[k][i] = 1'b0;
      end
      return;
    end
    if (m_st[k] == 1) begin
      for (int i = 0; i < NL; i++) ex[i] = (m_cnt[k][i] == 0);
      for (int i = 0; i < NL; i++) if (ex[i] && m_pend[k][i]) m_ovr[k] = 1'b1;
      for (int i = 0; i < NL; i++) m_pend[k][i] = m_pend[k][i] | ex[i];
      for (int i = 0; i < NL; i++) if (g < 0 && m_pend[k][i]) g = i;
      if (g >= 0) m_pend[k][g] = 1'b0;
      for (int i = 0; i < NL; i++)
        m_cnt[k][i] = ex[i] ? per(k, i, m_lv[k]) - 1 : m_cnt[k][i] - 1;
    end else if (m_st[k] != 2) begin
      for (int i = 0; i < NL; i++) begin
        m_cnt[k][i] = per(k, i, m_lv[k]) - 1;
        m_pend[k][i] = 1'b0;
      end
    end
    m_step[k] = (g >= 0) ? (1 << g) : 0;
    case (m_st[k])
      0: if (st) m_st[k] = 1;
      1: begin
        if (lu && !ht && m_lv[k] < 7) m_lv[k] = m_lv[k] + 1;
        if (ht) begin m_st[k] = 3; m_cc[k] = 0; end
        else if (pz) m_st[k] = 2;
      end
      2: if (!pz) m_st[k] = 1;
      default: begin
        m_cc[k] = m_cc[k] + 1;
        if (m_cc[k] == 8) m_st[k] = 0;
      end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int k);
    logic [NL-1:0] st;
    logic [2:0]    lv;
    logic [1:0]    s;
    logic          ov;
    if (k == 0) begin st = a_step; lv = a_level; s = a_state; ov = a_ovr; end
    else        begin st = b_step; lv = b_level; s = b_state; ov = b_ovr; end
    chk($sformatf("step_%0d", k),    32'(st), 32'(m_step[k]));
    chk($sformatf("level_%0d", k),   32'(lv), 32'(m_lv[k]));
    chk($sformatf("state_%0d", k),   32'(s),  32'(m_st[k]));
    chk($sformatf("overrun_%0d", k), 32'(ov), 32'(m_ovr[k]));
    chk($sformatf("onehot_%0d", k),  32'($onehot0(st)), 32'(1));
  endtask

  // ---------------- driver ----------------
  task automatic cycle();
    model_step(0, a_rst, a_start, a_pause, a_lvl, a_hit);
    model_step(1, b_rst, b_start, b_pause, b_lvl, b_hit);
    @(posedge clk);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [2:0] lvl_before;

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_pause = 1'b0; a_lvl = 1'b0; a_hit = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_pause = 1'b0; b_lvl = 1'b0; b_hit = 1'b0;
    #2;
    cycle();
    cycle();
    chk("reset_state", 32'(a_state), 32'(0));
    chk("reset_level", 32'(a_level), 32'(0));
    chk("reset_step",  32'(a_step),  32'(0));
    chk("reset_ovr",   32'(a_ovr),   32'(0));
    a_rst = 1'b0; b_rst = 1'b0;

    // start, then watch the first lane periods and the lane0/lane1 tie
    a_start = 1'b1; cycle(); a_start = 1'b0;
    chk("run_after_start", 32'(a_state), 32'(1));
    for (int n = 1; n <= 81; n++) begin
      cycle();
      if (n == 16) chk("lane0_first_step", 32'(a_step), 32'(4'b0001));
      if (n == 28) chk("lane3_first_step", 32'(a_step), 32'(4'b1000));
      if (n == 80) chk("tie_lane0",        32'(a_step), 32'(4'b0001));
      if (n == 81) chk("tie_lane1",        32'(a_step), 32'(4'b0010));
    end

    // level saturation
    a_lvl = 1'b1;
    for (int n = 0; n < 9; n++) cycle();
    a_lvl = 1'b0;
    chk("level_saturates", 32'(a_level), 32'(7));
    for (int n = 0; n < 40; n++) cycle();

    // pause freezes everything
    a_pause = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      cycle();
      if (n > 1) chk("pause_quiet", 32'(a_step), 32'(0));
    end
    a_pause = 1'b0;
    for (int n = 0; n < 30; n++) cycle();

    // hit beats pause and level_up
    lvl_before = a_level;
    a_hit = 1'b1; a_pause = 1'b1; a_lvl = 1'b1;
    cycle();
    a_hit = 1'b0; a_pause = 1'b0; a_lvl = 1'b0;
    chk("crash_entered", 32'(a_state), 32'(3));
    chk("crash_level",   32'(a_level), 32'(lvl_before));
    for (int n = 1; n <= 8; n++) begin
      cycle();
      chk("crash_quiet", 32'(a_step), 32'(0));
      if (n < 8) chk("crash_hold", 32'(a_state), 32'(3));
      else       chk("crash_to_idle", 32'(a_state), 32'(0));
    end
    chk("level_persists", 32'(a_level), 32'(lvl_before));

    // short-period instance: lanes queue up and re-expire while pending
    b_start = 1'b1; cycle(); b_start = 1'b0;
    for (int n = 0; n < 10; n++) cycle();
    chk("overrun_set", 32'(b_ovr), 32'(1));
    b_pause = 1'b1; for (int n = 0; n < 5; n++) cycle(); b_pause = 1'b0;
    chk("overrun_sticky", 32'(b_ovr), 32'(1));

    // randomized traffic on both instances
    for (int n = 0; n < 500; n++) begin
      a_rst   = ($urandom_range(0, 299) == 0);
      a_start = ($urandom_range(0, 7) == 0);
      a_pause = ($urandom_range(0, 9) < 2);
      a_lvl   = ($urandom_range(0, 9) == 0);
      a_hit   = ($urandom_range(0, 49) == 0);
      b_rst   = 1'b0;
      b_start = ($urandom_range(0, 3) == 0);
      b_pause = ($urandom_range(0, 9) < 3);
      b_lvl   = ($urandom_range(0, 19) == 0);
      b_hit   = ($urandom_range(0, 39) == 0);
      cycle();
    end
    a_rst = 1'b0; a_start = 1'b0; a_pause = 1'b0; a_lvl = 1'b0; a_hit = 1'b0;
    b_start = 1'b0; b_pause = 1'b0; b_lvl = 1'b0; b_hit = 1'b0;
    chk("overrun_still_set", 32'(b_ovr), 32'(1));

    b_rst = 1'b1; cycle(); b_rst = 1'b0;
    chk("overrun_cleared", 32'(b_ovr),   32'(0));
    chk("level_cleared",   32'(b_level), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
